// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester, response and ALU-side signal bundle for alu_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [3*NUM_REQ-1:0]  req_cmd_i;
  logic [32*NUM_REQ-1:0] req_lhs_i;
  logic [32*NUM_REQ-1:0] req_rhs_i;
  logic [NUM_REQ-1:0]    rsp_valid_o;
  logic [NUM_REQ-1:0]    rsp_ready_i;
  logic [31:0]           rsp_data_o;
  logic [2:0]            alu_cmd_o;
  logic [31:0]           alu_lhs_o;
  logic [31:0]           alu_rhs_o;
  logic [31:0]           alu_res_i;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_cmd_i, req_lhs_i, req_rhs_i, rsp_ready_i, alu_res_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, alu_cmd_o, alu_lhs_o, alu_rhs_o, busy_o
  );

  modport master (
    output req_valid_i, req_cmd_i, req_lhs_i, req_rhs_i, rsp_ready_i, alu_res_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, alu_cmd_o, alu_lhs_o, alu_rhs_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one combinational ALU among NUM_REQ requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_arbiter_if.slave  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [31:0]        lhs_q, lhs_d;
  logic [31:0]        rhs_q, rhs_d;
  logic [31:0]        res_q, res_d;

  logic               found;
  logic [GW-1:0]      pick;
  logic [GW:0]        scan;
  logic [NUM_REQ-1:0] ready;

  // Search starts at ptr and wraps; the first valid requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (GW+1)'(k);
      if (scan >= (GW+1)'(NUM_REQ)) begin
        scan = scan - (GW+1)'(NUM_REQ);
      end
      if (!found && bus.req_valid_i[scan[GW-1:0]]) begin
        found = 1'b1;
        pick  = scan[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cmd_d   = cmd_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    res_d   = res_q;
    ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (found && !rst_i) begin
          ready[pick] = 1'b1;
          grant_d     = pick;
          cmd_d       = bus.req_cmd_i[3*pick +: 3];
          lhs_d       = bus.req_lhs_i[32*pick +: 32];
          rhs_d       = bus.req_rhs_i[32*pick +: 32];
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = bus.alu_res_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready_i[grant_q]) begin
          ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cmd_q   <= 3'd0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_data_o  = res_q;
  assign bus.alu_cmd_o   = cmd_q;
  assign bus.alu_lhs_o   = lhs_q;
  assign bus.alu_rhs_o   = rhs_q;
  assign bus.busy_o      = (state_q != ST_IDLE);

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp_valid
      assign bus.rsp_valid_o[i] = (state_q == ST_RESP) && (grant_q == GW'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter with a behavioural ALU attached.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  localparam int N = 3;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SRA = 3'd7;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc = 0;
  int          grant_cyc = 0;
  int          mg;
  exp_t        me;
  exp_t        sb[$];
  int          grant_log[$];
  logic [31:0] last_rsp = '0;
  logic [N-1:0] prev_rv = '0;

  alu_arbiter_if #(.NUM_REQ(N)) bus ();

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      default: r = 32'($signed(a) >>> b[4:0]);
    endcase
    return r;
  endfunction

  always_comb bus.alu_res_i = alu_f(bus.alu_cmd_o, bus.alu_lhs_o, bus.alu_rhs_o);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  // Monitor: grants push the expected result, response handshakes pop it.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_rv = '0;
    end else begin
      if (bus.req_ready_o != '0) begin
        mg = first_set(bus.req_ready_o);
        check_eq("ready_onehot", 32'($countones(bus.req_ready_o)), 32'd1);
        check_eq("grant_was_valid", 32'(bus.req_valid_i[mg]), 32'd1);
        me.idx  = mg;
        me.data = alu_f(bus.req_cmd_i[3*mg +: 3], bus.req_lhs_i[32*mg +: 32], bus.req_rhs_i[32*mg +: 32]);
        sb.push_back(me);
        grant_log.push_back(mg);
        grant_cyc = cyc;
      end
      if (bus.rsp_valid_o != '0 && prev_rv == '0) begin
        check_eq("latency", 32'(cyc - grant_cyc), 32'd2);
      end
      if ((bus.rsp_valid_o & bus.rsp_ready_i) != '0) begin
        check_eq("rsp_onehot", 32'($countones(bus.rsp_valid_o)), 32'd1);
        check_eq("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          me = sb.pop_front();
          check_eq("rsp_index", 32'(first_set(bus.rsp_valid_o)), 32'(me.idx));
          check_eq("rsp_data", bus.rsp_data_o, me.data);
        end
        last_rsp = bus.rsp_data_o;
      end
      prev_rv = bus.rsp_valid_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(bus.req_ready_o), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd0);
    check_eq({tag, "_rsp_data"}, bus.rsp_data_o, 32'd0);
    check_eq({tag, "_alu_cmd"}, 32'(bus.alu_cmd_o), 32'd0);
    check_eq({tag, "_alu_lhs"}, bus.alu_lhs_o, 32'd0);
    check_eq({tag, "_alu_rhs"}, bus.alu_rhs_o, 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    tick(2);
    check_zero("reset");
    rst = 1'b0;
    sb.delete();
    grant_log.delete();
  endtask

  // Present one request and drop valid on the edge that accepts it.
  task automatic issue(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic got = 1'b0;
    bus.req_cmd_i[3*i +: 3]   = c;
    bus.req_lhs_i[32*i +: 32] = a;
    bus.req_rhs_i[32*i +: 32] = b;
    bus.req_valid_i[i]        = 1'b1;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      got = bus.req_ready_o[i];
    end
    check_eq("grant_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_i[i] = 1'b0;
  endtask

  task automatic contend(input logic [N-1:0] mask, input int n);
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      bus.req_cmd_i[3*i +: 3]   = 3'(i);
      bus.req_lhs_i[32*i +: 32] = 32'h1000 * 32'(i + 1);
      bus.req_rhs_i[32*i +: 32] = 32'(i + 3);
    end
    bus.req_valid_i = mask;
    for (int k = 0; k < 200 && grant_log.size() < n; k++) begin
      @(negedge clk);
      #1;
    end
    check_eq("contend_grants", 32'(grant_log.size()), 32'(n));
    @(posedge clk);
    #1;
    bus.req_valid_i = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && !(sb.size() == 0 && !bus.busy_o); k++) tick(1);
    check_eq("drain", 32'(sb.size() == 0 && !bus.busy_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = '0;
    bus.req_cmd_i   = '0;
    bus.req_lhs_i   = '0;
    bus.req_rhs_i   = '0;
    bus.rsp_ready_i = '0;
    do_reset();

    // Single request, response held until accepted.
    issue(0, OP_ADD, 32'd5, 32'd7);
    tick(1);
    check_eq("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'b001);
    check_eq("t1_rsp_data", bus.rsp_data_o, 32'd12);
    check_eq("t1_busy", 32'(bus.busy_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_eq("t1_hold_valid", 32'(bus.rsp_valid_o), 32'b001);
      check_eq("t1_hold_data", bus.rsp_data_o, 32'd12);
    end
    bus.rsp_ready_i = 3'b001;
    tick(1);
    check_eq("t1_released", 32'(bus.rsp_valid_o), 32'd0);
    check_eq("t1_idle", 32'(bus.busy_o), 32'd0);
    check_eq("t1_last", last_rsp, 32'd12);
    bus.rsp_ready_i = '1;

    // Contention from reset: 0, then 1, then 0 again.
    do_reset();
    contend(3'b011, 3);
    drain();
    check_eq("t2_order0", 32'(glog(0)), 32'd0);
    check_eq("t2_order1", 32'(glog(1)), 32'd1);
    check_eq("t2_order2", 32'(glog(2)), 32'd0);

    // Specific operations.
    issue(0, OP_SUB, 32'd3, 32'd5);
    drain();
    check_eq("t3_sub", last_rsp, 32'hFFFF_FFFE);
    issue(1, OP_SRA, 32'h8000_0000, 32'd33);
    drain();
    check_eq("t3_sra", last_rsp, 32'hC000_0000);
    issue(2, OP_SRL, 32'h8000_0000, 32'd33);
    drain();
    check_eq("t3_srl", last_rsp, 32'h4000_0000);
    for (int k = 0; k < 8; k++) begin
      issue(int'($urandom_range(0, N - 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      drain();
    end

    // Backpressure with wrong-index rsp_ready asserted.
    bus.rsp_ready_i = '0;
    issue(1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
    tick(1);
    check_eq("t4_rsp_valid", 32'(bus.rsp_valid_o), 32'b010);
    bus.req_cmd_i[2:0]  = OP_XOR;
    bus.req_lhs_i[31:0] = 32'hAAAA_5555;
    bus.req_rhs_i[31:0] = 32'hFFFF_0000;
    bus.req_valid_i[0]  = 1'b1;
    bus.rsp_ready_i     = 3'b101;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check_eq("t4_no_grant", 32'(bus.req_ready_o), 32'd0);
      check_eq("t4_hold_valid", 32'(bus.rsp_valid_o), 32'b010);
      check_eq("t4_hold_data", bus.rsp_data_o, 32'h0000_00FF);
    end
    bus.rsp_ready_i = '1;
    issue(0, OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
    drain();
    check_eq("t4_after", last_rsp, 32'h5555_5555);

    // Reset during EXEC.
    issue(2, OP_ADD, 32'd1, 32'd2);
    rst = 1'b1;
    #1;
    check_zero("rst_exec");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_eq("t5_no_rsp_a", 32'(bus.rsp_valid_o), 32'd0);
    end

    // Reset during RESP.
    bus.rsp_ready_i = '0;
    issue(1, OP_SUB, 32'd10, 32'd4);
    tick(1);
    check_eq("t5_in_resp", 32'(bus.rsp_valid_o), 32'b010);
    rst = 1'b1;
    #1;
    check_zero("rst_resp");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    bus.rsp_ready_i = '1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      check_eq("t5_no_rsp_b", 32'(bus.rsp_valid_o), 32'd0);
    end
    contend(3'b101, 1);
    drain();
    check_eq("t5_ptr_zero", 32'(glog(0)), 32'd0);

    // Three requesters continuously valid.
    do_reset();
    contend(3'b111, 6);
    drain();
    for (int i = 0; i < 6; i++) begin
      check_eq("t6_order", 32'(glog(i)), 32'(i % 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
